txframe_buffer: RTL and testbench
=================================

TXFRAME_BUFFER -- requirements
Module: txframe_buffer

Interface
REQ-001 SHALL have parameter AW, default 9, meaning log2 of buffer depth in 37-bit words ({tlast,tuser,tdata}).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port txif_fifo_tvalid  input  1  upstream beat valid (frame incrementer output).
REQ-005 SHALL have port txif_fifo_tready  output  1  upstream ready.
REQ-006 SHALL have port txif_fifo_tdata  input  32  upstream data.
REQ-007 SHALL have port txif_fifo_tlast  input  1  upstream last beat of frame.
REQ-008 SHALL have port txif_fifo_tuser  input  4  upstream sideband, stored per beat.
REQ-009 SHALL have port macif_tx_tvalid  output  1  downstream beat valid.
REQ-010 SHALL have port macif_tx_tready  input  1  downstream ready.
REQ-011 SHALL have ports macif_tx_tdata / macif_tx_tlast / macif_tx_tuser  output  32/1/4  downstream beat.
REQ-012 SHALL have ports frames_sent / frames_dropped  output  16/16  statistics counters (see Configuration).

Function
REQ-013 SHALL be store-and-forward: no beat of a frame is presented downstream until its tlast beat is written.
REQ-014 SHALL hold wr_ptr, commit_ptr, rd_ptr, each AW+1 bits, wrapping modulo 2^(AW+1); occupancy = wr_ptr - rd_ptr.
REQ-015 SHALL drive txif_fifo_tready = 1 in every cycle out of reset; input is never back-pressured.
REQ-016 SHALL write an accepted beat at wr_ptr and increment wr_ptr in state WRITE when occupancy < 2^AW.
REQ-017 SHALL, on an accepted tlast beat in WRITE with space, set commit_ptr = wr_ptr+1 at the same edge.
REQ-018 SHALL, on an accepted beat in WRITE while occupancy == 2^AW, restore wr_ptr = commit_ptr and enter DROP; if that beat has tlast, count the drop and stay in WRITE.
REQ-019 SHALL in DROP discard all beats; on the accepted tlast beat, increment frames_dropped and return to WRITE.
REQ-020 SHALL read only committed words (rd_ptr != commit_ptr) into a one-entry output register; macif_tx_* are driven from that register.
REQ-021 SHALL refill the output register in the same cycle it is consumed (valid&&ready) when a further committed word exists, sustaining one beat per clock.
REQ-022 SHALL assert macif_tx_tvalid exactly 2 clocks after the edge at which commit_ptr advances, given an empty buffer and empty output register.
REQ-023 SHALL hold macif_tx_tdata/tlast/tuser stable while macif_tx_tvalid=1 and macif_tx_tready=0.
REQ-024 SHALL increment frames_sent on each downstream handshake with macif_tx_tlast=1; counters wrap 0xFFFF->0x0000.
REQ-025 SHALL allow a write and a read in the same cycle; occupancy reflects both.
REQ-026 SHALL drop any frame longer than 2^AW words even with an empty buffer.

Reset
REQ-027 SHALL on rst_n=0 clear all pointers, state to WRITE, output register empty, counters to 0.
REQ-028 SHALL reset outputs to macif_tx_tvalid=0, macif_tx_tdata=0, macif_tx_tlast=0, macif_tx_tuser=0, txif_fifo_tready=0.
REQ-029 SHALL discard partial and committed frames on reset mid-operation; first beat after reset release starts a new frame.
REQ-030 SHALL leave memory array contents unreset.

Configuration
REQ-031 SHALL compile frame statistics counters only when macro TXFRAME_BUFFER_STATS_EN is defined.
REQ-032 SHALL, without TXFRAME_BUFFER_STATS_EN, keep frames_sent and frames_dropped ports and drive both constant 0; data path unchanged.

Verification
REQ-033 SHALL cover: AW=4, one 3-beat frame 0x11,0x22,0x33(tlast), tuser=0x5, ready=1 -> tvalid 2 clocks after tlast edge, 3 beats in order, tuser 0x5, frames_sent=1.
REQ-034 SHALL cover: AW=4, 20-beat frame -> nothing emitted, frames_dropped=1, then 2-beat frame passes intact.
REQ-035 SHALL cover: AW=4, 10-beat frame committed, ready=0, then 10-beat frame -> second dropped, first emitted intact on ready=1.
REQ-036 SHALL cover: random ready toggling on 5 back-to-back 4-beat frames -> data stable under stall, 20 beats in order, frames_sent=5.
REQ-037 SHALL cover: rst_n low for 1 cycle mid-frame and mid-output -> tvalid=0 and counters 0 immediately, next frame correct.
REQ-038 SHALL cover: build without TXFRAME_BUFFER_STATS_EN, scenario REQ-034 -> frames_dropped stays 0, data identical.

Source files
------------

// File: rtl/txframe_buffer.sv
// rtl/txframe_buffer.sv - store-and-forward TX frame buffer with commit pointer and oversize/full drop
// Optional frame statistics counters are built when TXFRAME_BUFFER_STATS_EN is defined.
module txframe_buffer #(
    parameter int AW = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        txif_fifo_tvalid,
    output logic        txif_fifo_tready,
    input  logic [31:0] txif_fifo_tdata,
    input  logic        txif_fifo_tlast,
    input  logic [3:0]  txif_fifo_tuser,
    output logic        macif_tx_tvalid,
    input  logic        macif_tx_tready,
    output logic [31:0] macif_tx_tdata,
    output logic        macif_tx_tlast,
    output logic [3:0]  macif_tx_tuser,
    output logic [15:0] frames_sent,
    output logic [15:0] frames_dropped
);

    typedef enum logic {ST_WRITE, ST_DROP} state_t;

    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    state_t      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] commit_ptr_q, commit_ptr_d;
    logic [AW:0] commit_vis_q;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] occupancy;
    logic        ready_q;
    logic        accept, full, wr_en, drop_pulse;
    logic        rd_avail, load;
    logic [36:0] out_q;
    logic        out_valid_q;
    logic [36:0] mem [0:(1<<AW)-1];

    assign accept    = txif_fifo_tvalid && ready_q;
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign full      = (occupancy == DEPTH);

    // Reads see commits one cycle late so the first beat appears two clocks after commit.
    assign rd_avail = (rd_ptr_q != commit_vis_q);
    assign load     = rd_avail && (!out_valid_q || macif_tx_tready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WRITE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            commit_vis_q <= '0;
            rd_ptr_q     <= '0;
            ready_q      <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            commit_vis_q <= commit_ptr_q;
            ready_q      <= 1'b1;
            if (load) begin
                out_q       <= mem[rd_ptr_q[AW-1:0]];
                out_valid_q <= 1'b1;
                rd_ptr_q    <= rd_ptr_q + PTR_ONE;
            end else if (macif_tx_tready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WRITE: if (accept && full && !txif_fifo_tlast) state_d = ST_DROP;
            ST_DROP:  if (accept && txif_fifo_tlast) state_d = ST_WRITE;
            default:  state_d = ST_WRITE;
        endcase
    end

    // A beat arriving at a full buffer rewinds to the last commit, discarding the partial frame.
    always_comb begin
        wr_en        = 1'b0;
        drop_pulse   = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        case (state_q)
            ST_WRITE: begin
                if (accept) begin
                    if (!full) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                        if (txif_fifo_tlast) commit_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        wr_ptr_d   = commit_ptr_q;
                        drop_pulse = txif_fifo_tlast;
                    end
                end
            end
            ST_DROP: drop_pulse = accept && txif_fifo_tlast;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {txif_fifo_tlast, txif_fifo_tuser, txif_fifo_tdata};
    end

    assign txif_fifo_tready = ready_q;
    assign macif_tx_tvalid  = out_valid_q;
    assign macif_tx_tdata   = out_q[31:0];
    assign macif_tx_tuser   = out_q[35:32];
    assign macif_tx_tlast   = out_q[36];

`ifdef TXFRAME_BUFFER_STATS_EN
    logic [15:0] sent_q, dropped_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_q    <= '0;
            dropped_q <= '0;
        end else begin
            if (out_valid_q && macif_tx_tready && out_q[36]) sent_q <= sent_q + 16'd1;
            if (drop_pulse) dropped_q <= dropped_q + 16'd1;
        end
    end

    assign frames_sent    = sent_q;
    assign frames_dropped = dropped_q;
`else
    logic stats_unused;
    assign stats_unused   = drop_pulse;
    assign frames_sent    = 16'd0;
    assign frames_dropped = 16'd0;
`endif

endmodule

// File: tb/tb_txframe_buffer.sv
// tb/tb_txframe_buffer.sv - directed self-checking bench for txframe_buffer (AW=4)
module tb_txframe_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        txif_fifo_tvalid;
    logic        txif_fifo_tready;
    logic [31:0] txif_fifo_tdata;
    logic        txif_fifo_tlast;
    logic [3:0]  txif_fifo_tuser;
    logic        macif_tx_tvalid;
    logic        macif_tx_tready;
    logic [31:0] macif_tx_tdata;
    logic        macif_tx_tlast;
    logic [3:0]  macif_tx_tuser;
    logic [15:0] frames_sent;
    logic [15:0] frames_dropped;

    always #5 clk = ~clk;

    txframe_buffer #(.AW(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .txif_fifo_tvalid (txif_fifo_tvalid),
        .txif_fifo_tready (txif_fifo_tready),
        .txif_fifo_tdata  (txif_fifo_tdata),
        .txif_fifo_tlast  (txif_fifo_tlast),
        .txif_fifo_tuser  (txif_fifo_tuser),
        .macif_tx_tvalid  (macif_tx_tvalid),
        .macif_tx_tready  (macif_tx_tready),
        .macif_tx_tdata   (macif_tx_tdata),
        .macif_tx_tlast   (macif_tx_tlast),
        .macif_tx_tuser   (macif_tx_tuser),
        .frames_sent      (frames_sent),
        .frames_dropped   (frames_dropped)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] cnt(input logic [15:0] v);
`ifdef TXFRAME_BUFFER_STATS_EN
        return v;
`else
        return 16'd0;
`endif
    endfunction

    logic [36:0] rx_q[$];
    logic [36:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [36:0] prev_word  = '0;
    logic [15:0] rdy_pat    = 16'b1011_0110_1101_1011;
    logic        rdy_stop;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {27'd0, macif_tx_tvalid, macif_tx_tlast, macif_tx_tuser, macif_tx_tdata},
                      {27'd0, 1'b1, prev_word});
            prev_stall <= macif_tx_tvalid && !macif_tx_tready;
            prev_word  <= {macif_tx_tlast, macif_tx_tuser, macif_tx_tdata};
            if (macif_tx_tvalid && macif_tx_tready)
                rx_q.push_back({macif_tx_tlast, macif_tx_tuser, macif_tx_tdata});
        end
    end

    task automatic send(input logic [31:0] d, input logic [3:0] u, input logic l);
        txif_fifo_tvalid = 1'b1;
        txif_fifo_tdata  = d;
        txif_fifo_tuser  = u;
        txif_fifo_tlast  = l;
        @(posedge clk);
        #1;
        txif_fifo_tvalid = 1'b0;
        txif_fifo_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] base, input int n, input logic [3:0] u);
        for (int i = 0; i < n; i++) send(base + i, u, i == n - 1);
    endtask

    task automatic expect_frame(input logic [31:0] base, input int n, input logic [3:0] u);
        for (int i = 0; i < n; i++) exp_q.push_back({i == n - 1, u, base + i});
    endtask

    task automatic drain(input string tag);
        int n;
        int waited;
        n = exp_q.size();
        waited = 0;
        while (rx_q.size() < n && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        repeat (4) @(negedge clk);
        check({tag, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < rx_q.size()) check({tag, "_beat"}, rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n            = 1'b0;
        txif_fifo_tvalid = 1'b0;
        txif_fifo_tdata  = '0;
        txif_fifo_tlast  = 1'b0;
        txif_fifo_tuser  = '0;
        macif_tx_tready  = 1'b1;
        rdy_stop         = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_tvalid", macif_tx_tvalid, 0);
        check("rst_tdata", macif_tx_tdata, 0);
        check("rst_tlast", macif_tx_tlast, 0);
        check("rst_tuser", macif_tx_tuser, 0);
        check("rst_tready", txif_fifo_tready, 0);
        check("rst_sent", frames_sent, 0);
        check("rst_dropped", frames_dropped, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("tready_up", txif_fifo_tready, 1);
        @(posedge clk); #1;

        // 3-beat frame: tvalid must rise exactly two clocks after the tlast edge
        send(32'h11, 4'h5, 1'b0);
        send(32'h22, 4'h5, 1'b0);
        send(32'h33, 4'h5, 1'b1);
        @(negedge clk);
        check("lat_c0", macif_tx_tvalid, 0);
        @(negedge clk);
        check("lat_c1", macif_tx_tvalid, 0);
        @(negedge clk);
        check("lat_c2_valid", macif_tx_tvalid, 1);
        check("lat_c2_data", macif_tx_tdata, 32'h11);
        exp_q.push_back({1'b0, 4'h5, 32'h11});
        exp_q.push_back({1'b0, 4'h5, 32'h22});
        exp_q.push_back({1'b1, 4'h5, 32'h33});
        drain("f3");
        check("f3_sent", frames_sent, cnt(16'd1));

        // oversize frame dropped even with an empty buffer
        send_frame(32'h100, 20, 4'h1);
        repeat (10) @(negedge clk);
        check("big_none", rx_q.size(), 0);
        check("big_tvalid", macif_tx_tvalid, 0);
        check("big_dropped", frames_dropped, cnt(16'd1));
        @(posedge clk); #1;
        send_frame(32'hA0, 2, 4'h3);
        expect_frame(32'hA0, 2, 4'h3);
        drain("after_big");
        check("after_big_sent", frames_sent, cnt(16'd2));
        check("after_big_dropped", frames_dropped, cnt(16'd1));

        // stalled output: second frame overflows and is dropped, first survives
        macif_tx_tready = 1'b0;
        send_frame(32'h200, 10, 4'h2);
        send_frame(32'h300, 10, 4'h3);
        repeat (5) @(negedge clk);
        check("full_hold_valid", macif_tx_tvalid, 1);
        check("full_hold_data", macif_tx_tdata, 32'h200);
        check("full_dropped", frames_dropped, cnt(16'd2));
        @(posedge clk); #1 macif_tx_tready = 1'b1;
        expect_frame(32'h200, 10, 4'h2);
        drain("full");
        check("full_sent", frames_sent, cnt(16'd3));

        // five back-to-back frames under a toggling ready pattern
        for (int f = 0; f < 5; f++) expect_frame(32'h400 + 4 * f, 4, f[3:0]);
        fork
            begin
                for (int f = 0; f < 5; f++) send_frame(32'h400 + 4 * f, 4, f[3:0]);
                drain("toggle");
                rdy_stop = 1'b1;
            end
            begin
                int k;
                k = 0;
                while (!rdy_stop) begin
                    @(posedge clk); #1;
                    macif_tx_tready = rdy_pat[k % 16];
                    k++;
                end
            end
        join
        macif_tx_tready = 1'b1;
        check("toggle_sent", frames_sent, cnt(16'd8));
        check("toggle_dropped", frames_dropped, cnt(16'd2));

        // reset mid-output and mid-frame
        @(posedge clk); #1 macif_tx_tready = 1'b0;
        send_frame(32'h500, 3, 4'h6);
        send(32'h510, 4'h7, 1'b0);
        send(32'h511, 4'h7, 1'b0);
        repeat (3) @(negedge clk);
        check("pre_rst_valid", macif_tx_tvalid, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", macif_tx_tvalid, 0);
        check("mid_rst_sent", frames_sent, 0);
        check("mid_rst_dropped", frames_dropped, 0);
        check("mid_rst_tready", txif_fifo_tready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
        macif_tx_tready = 1'b1;
        @(posedge clk); #1;
        repeat (6) @(negedge clk);
        check("post_rst_idle", macif_tx_tvalid, 0);
        @(posedge clk); #1;
        send_frame(32'h600, 2, 4'h9);
        expect_frame(32'h600, 2, 4'h9);
        drain("post_rst");
        check("post_rst_sent", frames_sent, cnt(16'd1));
        check("post_rst_dropped", frames_dropped, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
